ofmap_collector: RTL

Downstream stage of the systolic MAC array. Removes the per-column output skew, accumulates partial-sum vectors over several K-tile passes in a local buffer, then drains finished output rows over a valid/ready stream toward the ofmap writeback path. Each K-tile of a layer is streamed through the array once; this block sums the passes.

---
 rtl/ofmap_collector_pkg.sv | 37 +++
 rtl/ofmap_collector_skew_delay.sv | 55 +++++
 rtl/ofmap_collector.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ofmap_collector_pkg.sv
// ofmap_collector_pkg
//   Shared types and helpers for the ofmap collector.
//   state_e     : collector FSM states.
//   lane_vec_t  : one output vector at the default array geometry
//                 (16 lanes x 32 bits); parameterised instances declare
//                 the same shape locally from their own parameters.
//   clamp_cfg   : maps a raw configuration count onto 1..max_val.
package ofmap_collector_pkg;

    localparam int MAC_COL_DEF        = 16;
    localparam int OFMAP_BITWIDTH_DEF = 32;
    localparam int ACC_DEPTH_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic [MAC_COL_DEF-1:0][OFMAP_BITWIDTH_DEF-1:0] lane_vec_t;

    // A zero count still means one unit of work; anything above the
    // capacity is pinned to the capacity.
    function automatic int unsigned clamp_cfg(input int unsigned val,
                                              input int unsigned max_val);
        int unsigned res;
        if (val == 0) begin
            res = 1;
        end else if (val > max_val) begin
            res = max_val;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/ofmap_collector_skew_delay.sv
// skew_delay
//   DEPTH-stage register line carrying a valid bit and a W-bit data word
//   side by side. DEPTH=0 degenerates to a straight wire.
//   clk, rstn  : clock, asynchronous active-low reset (clears valids)
//   valid_in   : valid entering the line
//   data_in    : data entering the line
//   valid_out  : valid after DEPTH cycles
//   data_out   : data after DEPTH cycles
module skew_delay #(
    parameter int W     = 32,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid_out,
    output logic [W-1:0] data_out
);

    if (DEPTH == 0) begin : g_wire
        assign valid_out = valid_in;
        assign data_out  = data_in;
    end else begin : g_pipe
        logic [DEPTH-1:0]        vld_q;
        logic [DEPTH-1:0]        vld_d;
        logic [DEPTH-1:0][W-1:0] dat_q;
        logic [DEPTH-1:0][W-1:0] dat_d;

        always_comb begin
            vld_d    = '0;
            dat_d    = '0;
            vld_d[0] = valid_in;
            dat_d[0] = data_in;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign valid_out = vld_q[DEPTH-1];
        assign data_out  = dat_q[DEPTH-1];
    end

endmodule

// File: rtl/ofmap_collector.sv
// ofmap_collector
//   Deskews the per-column psum stream from the MAC array, sums several
//   K-tile passes into a local vector buffer and drains the finished
//   vectors over a valid/ready stream.
//   clk, rstn        : clock, asynchronous active-low reset
//   ofmap_valid_in   : per-column valid, column m lags column 0 by m cycles
//   ofmap_data_in    : per-column psum (signed, wraps on accumulate)
//   start_in         : start pulse, latches cfg, taken only in IDLE
//   cfg_vectors_in   : vectors per pass (0 -> 1, clamped to ACC_DEPTH)
//   cfg_passes_in    : number of passes (0 -> 1)
//   out_valid/ready  : drain handshake
//   out_data         : accumulated vector, zero outside DRAIN
//   busy_out         : not in IDLE
//   done_out         : one-cycle pulse after the last drain accept
//   err_out          : sticky; skewed-valid mismatch or stray vector
//
//   state | meaning
//   IDLE  | waiting for start_in; stray vectors dropped, flag error
//   ACCUM | writing/accumulating aligned vectors into the buffer
//   DRAIN | presenting buf[rptr] until the last entry is accepted
module ofmap_collector
    import ofmap_collector_pkg::*;
#(
    parameter int MAC_COL        = 16,
    parameter int OFMAP_BITWIDTH = 32,
    parameter int ACC_DEPTH      = 16
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [MAC_COL-1:0]                     ofmap_valid_in,
    input  logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] ofmap_data_in,
    input  logic                                   start_in,
    input  logic [$clog2(ACC_DEPTH+1)-1:0]         cfg_vectors_in,
    input  logic [7:0]                             cfg_passes_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] out_data,
    output logic                                   busy_out,
    output logic                                   done_out,
    output logic                                   err_out
);

    localparam int PW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    typedef logic [MAC_COL-1:0][OFMAP_BITWIDTH-1:0] vec_t;

    logic [MAC_COL-1:0] al_valid;
    vec_t               al_data;
    logic               vec_valid;
    logic               lane_err;

    // Column m waits MAC_COL-1-m cycles so every lane lines up with the
    // last column, which arrives undelayed.
    for (genvar m = 0; m < MAC_COL; m++) begin : g_col
        skew_delay #(
            .W     (OFMAP_BITWIDTH),
            .DEPTH (MAC_COL - 1 - m)
        ) u_skew (
            .clk       (clk),
            .rstn      (rstn),
            .valid_in  (ofmap_valid_in[m]),
            .data_in   (ofmap_data_in[m]),
            .valid_out (al_valid[m]),
            .data_out  (al_data[m])
        );
    end

    assign vec_valid = al_valid[0];
    assign lane_err  = (al_valid != {MAC_COL{al_valid[0]}});

    state_e         state_q, state_d;
    logic [PW-1:0]  vec_last_q, vec_last_d;
    logic [7:0]     pass_last_q, pass_last_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [7:0]     pass_q, pass_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    vec_t           buf_q [ACC_DEPTH];
    logic           buf_we;
    vec_t           entry_d;
    vec_t           acc_sum;

    always_comb begin
        for (int l = 0; l < MAC_COL; l++) begin
            acc_sum[l] = buf_q[wptr_q][l] + al_data[l];
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_last_d  = vec_last_q;
        pass_last_d = pass_last_q;
        wptr_d      = wptr_q;
        pass_d      = pass_q;
        rptr_d      = rptr_q;
        err_d       = err_q;
        done_d      = 1'b0;
        buf_we      = 1'b0;
        entry_d     = al_data;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    vec_last_d  = PW'(clamp_cfg(32'(cfg_vectors_in), ACC_DEPTH) - 1);
                    pass_last_d = 8'(clamp_cfg(32'(cfg_passes_in), 255) - 1);
                    wptr_d      = '0;
                    pass_d      = '0;
                    rptr_d      = '0;
                    err_d       = 1'b0;
                    state_d     = ACCUM;
                end
                if (vec_valid) begin
                    err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (vec_valid) begin
                    buf_we  = 1'b1;
                    entry_d = (pass_q == 8'd0) ? al_data : acc_sum;
                    if (wptr_q == vec_last_q) begin
                        wptr_d = '0;
                        if (pass_q == pass_last_q) begin
                            state_d = DRAIN;
                        end else begin
                            pass_d = pass_q + 8'd1;
                        end
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (vec_valid) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    if (rptr_q == vec_last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rptr_d = rptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A lane disagreeing with lane 0 is flagged in any state, even
        // when it coincides with a start that clears the flag.
        if (lane_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            vec_last_q  <= '0;
            pass_last_q <= '0;
            wptr_q      <= '0;
            pass_q      <= '0;
            rptr_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_last_q  <= vec_last_d;
            pass_last_q <= pass_last_d;
            wptr_q      <= wptr_d;
            pass_q      <= pass_d;
            rptr_q      <= rptr_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    // Buffer holds data only; it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wptr_q] <= entry_d;
        end
    end

    assign out_valid = (state_q == DRAIN);
    assign out_data  = out_valid ? buf_q[rptr_q] : '0;
    assign busy_out  = (state_q != IDLE);
    assign done_out  = done_q;
    assign err_out   = err_q;

endmodule
